// File: rtl/sig_capture.sv
// sig_capture: trigger-positioned probe capture into one SDP RAM, dumped oldest-first as LSB-first bytes; trigger latency 1 clk.
// rd_data holds under rd_ready backpressure; define SIG_CAPTURE_EDGE_TRIG_EN to add trig_edge for per-bit edge triggers.
module sig_capture #(
  parameter int PROBE_W  = 40,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
`ifdef SIG_CAPTURE_EDGE_TRIG_EN
  input  logic [PROBE_W-1:0] trig_edge,
`endif
  input  logic               arm,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  input  logic               rd_ready
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int NB     = (PROBE_W + 7) / 8;
  localparam int BW     = NB * 8;
  localparam int BIW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [CW-1:0]  PRE_LAST    = CW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [CW-1:0]  POST_LAST   = CW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [CW-1:0]  SAMPLE_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0]  RD_TOTAL    = CW'(DEPTH);
  localparam logic [BIW-1:0] BYTE_LAST   = BIW'(NB - 1);
  localparam logic [AW-1:0]  PRE_OFS     = AW'(PRE_TRIG);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DUMP
  } state_t;

  state_t             state_q, state_d;
  logic [PROBE_W-1:0] probe_q, probe_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               ram_vld_q, ram_vld_d;
  logic [BW-1:0]      sample_q, sample_d;
  logic [BIW-1:0]     byte_q, byte_d;
  logic               rd_valid_q, rd_valid_d;

  logic               wr_en;
  logic               ram_rd_en;
  logic               xfer;
  logic               last_byte;
  logic               load;
  logic               trig_hit;

  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] ram_rd_q;

`ifdef SIG_CAPTURE_EDGE_TRIG_EN
  logic [PROBE_W-1:0] prev_q, prev_d;
  logic [PROBE_W-1:0] edge_bits;

  assign prev_d = probe_q;

  // Edge bits need current == value and the previous sample != value; the rest compare by level.
  always_comb begin
    edge_bits = trig_mask & trig_edge;
    trig_hit  = (((probe_q ^ trig_value) & trig_mask & ~trig_edge) == '0) &&
                (((prev_q ^ trig_value) & ~(probe_q ^ trig_value) & edge_bits) == edge_bits);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign trig_hit = ((probe_q ^ trig_value) & trig_mask) == '0;
`endif

  always_comb begin
    state_d    = state_q;
    probe_d    = probe;
    wr_ptr_d   = wr_ptr_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = rd_cnt_q;
    ram_vld_d  = ram_vld_q;
    sample_d   = sample_q;
    byte_d     = byte_q;
    rd_valid_d = rd_valid_q;
    wr_en      = 1'b0;
    ram_rd_en  = 1'b0;
    xfer       = rd_valid_q & rd_ready;
    last_byte  = (byte_q == BYTE_LAST);
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          wr_ptr_d   = '0;
          cnt_d      = '0;
          rd_cnt_d   = '0;
          ram_vld_d  = 1'b0;
          rd_valid_d = 1'b0;
          byte_d     = '0;
          state_d    = (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
        end
      end

      PRE: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_TRIG;
        end
      end

      WAIT_TRIG: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (trig_hit) begin
          // Oldest retained sample sits PRE_TRIG slots behind the trigger slot.
          rd_addr_d = wr_ptr_q - PRE_OFS;
          cnt_d     = '0;
          state_d   = (POST_N == 0) ? DUMP : POST;
        end
      end

      POST: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == POST_LAST) begin
          cnt_d   = '0;
          state_d = DUMP;
        end
      end

      DUMP: begin
        // ram_rd_q acts as a one-word prefetch so the byte stream has no bubbles between samples.
        load = ram_vld_q && (!rd_valid_q || (xfer && last_byte));
        if ((rd_cnt_q != RD_TOTAL) && (!ram_vld_q || load)) begin
          ram_rd_en = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
          rd_cnt_d  = rd_cnt_q + CW'(1);
          ram_vld_d = 1'b1;
        end else if (load) begin
          ram_vld_d = 1'b0;
        end

        if (xfer) begin
          sample_d = sample_q >> 8;
          byte_d   = byte_q + BIW'(1);
          if (last_byte) begin
            byte_d     = '0;
            rd_valid_d = 1'b0;
            cnt_d      = cnt_q + CW'(1);
            if (cnt_q == SAMPLE_LAST) begin
              state_d = IDLE;
            end
          end
        end

        if (load) begin
          sample_d                = '0;
          sample_d[PROBE_W-1:0]   = ram_rd_q;
          byte_d                  = '0;
          rd_valid_d              = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      probe_q    <= '0;
      wr_ptr_q   <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      ram_vld_q  <= 1'b0;
      sample_q   <= '0;
      byte_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      probe_q    <= probe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ram_vld_q  <= ram_vld_d;
      sample_q   <= sample_d;
      byte_q     <= byte_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Simple dual-port RAM with registered read, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= probe_q;
    end
    if (ram_rd_en) begin
      ram_rd_q <= mem[rd_addr_q];
    end
  end

  assign armed     = (state_q == PRE) || (state_q == WAIT_TRIG);
  assign triggered = (state_q == POST) || (state_q == DUMP);
  assign done      = (state_q == DUMP);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = sample_q[7:0];

endmodule
